// File: rtl/uart_rx_fifo_if.sv
// Reader/writer/status bundle for the UART receive FIFO.
// The master side drives the RX strobes and reader controls; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  i_wr_valid;
  logic [WIDTH-1:0]      i_wr_data;
  logic                  i_parity_error;
  logic                  i_stop_error;
  logic                  i_rd_ready;
  logic                  i_clr_status;
  logic                  o_rd_valid;
  logic [WIDTH-1:0]      o_rd_data;
  logic                  o_full;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_overrun;
  logic [CNT_WIDTH-1:0]  o_par_err_cnt;
  logic [CNT_WIDTH-1:0]  o_stp_err_cnt;

  modport master (
    output i_wr_valid, i_wr_data, i_parity_error, i_stop_error, i_rd_ready, i_clr_status,
    input  o_rd_valid, o_rd_data, o_full, o_empty, o_level, o_overrun,
           o_par_err_cnt, o_stp_err_cnt
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_parity_error, i_stop_error, i_rd_ready, i_clr_status,
    output o_rd_valid, o_rd_data, o_full, o_empty, o_level, o_overrun,
           o_par_err_cnt, o_stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through circular FIFO with sticky overrun
// and saturating parity/stop error-frame counters.
module uart_rx_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0]  LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  overrun_q, overrun_d;
  logic                  par_q, stp_q;
  logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d, stp_cnt_q, stp_cnt_d;
  logic                  push, pop, drop, par_rise, stp_rise;

  assign pop      = ~empty_q & bus.i_rd_ready;
  assign push     = bus.i_wr_valid & (~full_q | pop);
  assign drop     = bus.i_wr_valid & full_q & ~pop;
  assign par_rise = bus.i_parity_error & ~par_q;
  assign stp_rise = bus.i_stop_error & ~stp_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    par_cnt_d = par_cnt_q;
    stp_cnt_d = stp_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LEVEL_FULL);
    empty_d = (level_d == '0);

    // Clear is applied first so a same-cycle event overrides it (flag=1 / count=1).
    if (bus.i_clr_status) begin
      overrun_d = 1'b0;
      par_cnt_d = '0;
      stp_cnt_d = '0;
    end
    if (drop) overrun_d = 1'b1;
    if (par_rise && par_cnt_d != CNT_MAX) par_cnt_d = par_cnt_d + CNT_WIDTH'(1);
    if (stp_rise && stp_cnt_d != CNT_MAX) stp_cnt_d = stp_cnt_d + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
      par_q     <= 1'b0;
      stp_q     <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      overrun_q <= overrun_d;
      par_q     <= bus.i_parity_error;
      stp_q     <= bus.i_stop_error;
      par_cnt_q <= par_cnt_d;
      stp_cnt_q <= stp_cnt_d;
    end
  end

  // Storage is deliberately unreset; validity is tracked by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end

  assign bus.o_rd_valid    = ~empty_q;
  assign bus.o_rd_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.o_full        = full_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_level       = level_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_par_err_cnt = par_cnt_q;
  assign bus.o_stp_err_cnt = stp_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: FWFT data path, full/overrun
// handling, pointer wrap, error counters, status clear and mid-run reset.
module tb_uart_rx_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  uart_rx_fifo_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_wr_valid     = 1'b0;
    bus.i_wr_data      = '0;
    bus.i_parity_error = 1'b0;
    bus.i_stop_error   = 1'b0;
    bus.i_rd_ready     = 1'b0;
    bus.i_clr_status   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", bus.o_empty); end
    total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.o_full); end
    total++; if (bus.o_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.o_level); end
    total++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== 8'h00) begin bad++;
      $display("FAIL reset_rd got valid=%0b data=%h exp valid=0 data=00", bus.o_rd_valid, bus.o_rd_data); end
    total++; if (bus.o_overrun !== 1'b0 || bus.o_par_err_cnt !== 8'd0 || bus.o_stp_err_cnt !== 8'd0) begin bad++;
      $display("FAIL reset_status got ovr=%0b par=%0d stp=%0d exp 0/0/0", bus.o_overrun, bus.o_par_err_cnt, bus.o_stp_err_cnt); end
  endtask

  task automatic test_single();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'hA5;
    step();
    bus.i_wr_valid = 1'b0;
    total++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 8'hA5 || bus.o_level !== 5'd1) begin bad++;
      $display("FAIL single_push got valid=%0b data=%h level=%0d exp 1/a5/1", bus.o_rd_valid, bus.o_rd_data, bus.o_level); end
    bus.i_rd_ready = 1'b1;
    step();
    bus.i_rd_ready = 1'b0;
    total++; if (bus.o_empty !== 1'b1 || bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== 8'h00) begin bad++;
      $display("FAIL single_pop got empty=%0b valid=%0b data=%h exp 1/0/00", bus.o_empty, bus.o_rd_valid, bus.o_rd_data); end
  endtask

  task automatic test_empty_push_ready();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'h3C;
    bus.i_rd_ready = 1'b1;
    step();
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    total++; if (bus.o_level !== 5'd1 || bus.o_rd_data !== 8'h3C) begin bad++;
      $display("FAIL empty_push_ready got level=%0d data=%h exp 1/3c", bus.o_level, bus.o_rd_data); end
    bus.i_rd_ready = 1'b1;
    step();
    bus.i_rd_ready = 1'b0;
  endtask

  task automatic test_fill_overrun();
    int errs;
    logic [7:0] exp_b;
    for (int i = 0; i < 16; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'(i);
      step();
    end
    total++; if (bus.o_full !== 1'b1 || bus.o_level !== 5'd16 || bus.o_overrun !== 1'b0) begin bad++;
      $display("FAIL fill_full got full=%0b level=%0d ovr=%0b exp 1/16/0", bus.o_full, bus.o_level, bus.o_overrun); end
    bus.i_wr_data = 8'hFF;
    step();
    bus.i_wr_valid = 1'b0;
    total++; if (bus.o_overrun !== 1'b1 || bus.o_level !== 5'd16) begin bad++;
      $display("FAIL overrun_flag got ovr=%0b level=%0d exp 1/16", bus.o_overrun, bus.o_level); end
    errs = 0;
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i);
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== exp_b) begin
        errs++;
        $display("FAIL drain_data idx=%0d got valid=%0b data=%h exp 1/%h", i, bus.o_rd_valid, bus.o_rd_data, exp_b);
      end
      step();
    end
    bus.i_rd_ready = 1'b0;
    total++; if (errs != 0) bad++;
    total++; if (bus.o_empty !== 1'b1 || bus.o_rd_valid !== 1'b0 || bus.o_overrun !== 1'b1) begin bad++;
      $display("FAIL drain_end got empty=%0b valid=%0b ovr=%0b exp 1/0/1", bus.o_empty, bus.o_rd_valid, bus.o_overrun); end
  endtask

  task automatic test_full_push_pop();
    int errs;
    logic [7:0] exp_b;
    bus.i_clr_status = 1'b1;
    step();
    bus.i_clr_status = 1'b0;
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%0b exp=0", bus.o_overrun); end
    for (int i = 0; i < 16; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'(8'h10 + i);
      step();
    end
    bus.i_wr_data  = 8'h55;
    bus.i_rd_ready = 1'b1;
    step();
    bus.i_wr_valid = 1'b0;
    total++; if (bus.o_level !== 5'd16 || bus.o_full !== 1'b1 || bus.o_overrun !== 1'b0) begin bad++;
      $display("FAIL full_push_pop got level=%0d full=%0b ovr=%0b exp 16/1/0", bus.o_level, bus.o_full, bus.o_overrun); end
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 15) ? 8'h55 : 8'(8'h11 + i);
      if (bus.o_rd_data !== exp_b) begin
        errs++;
        $display("FAIL full_pp_drain idx=%0d got=%h exp=%h", i, bus.o_rd_data, exp_b);
      end
      step();
    end
    bus.i_rd_ready = 1'b0;
    total++; if (errs != 0 || bus.o_empty !== 1'b1) begin bad++;
      $display("FAIL full_pp_end got errs=%0d empty=%0b exp 0/1", errs, bus.o_empty); end
  endtask

  task automatic test_wrap_random();
    logic [7:0] q[$];
    int sent, errs, cyc;
    logic pop_m, push_m;
    sent = 0; errs = 0; cyc = 0;
    while ((sent < 40 || q.size() > 0) && cyc < 1000) begin
      bus.i_wr_valid = (sent < 40);
      bus.i_wr_data  = 8'(8'hC0 + sent);
      bus.i_rd_ready = 1'($urandom_range(0, 1));
      if (bus.o_rd_valid !== (q.size() > 0)) begin
        errs++; $display("FAIL wrap_valid cyc=%0d got=%0b exp=%0b", cyc, bus.o_rd_valid, q.size() > 0);
      end else if (q.size() > 0 && bus.o_rd_data !== q[0]) begin
        errs++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, bus.o_rd_data, q[0]);
      end
      pop_m  = (q.size() > 0) && bus.i_rd_ready;
      push_m = bus.i_wr_valid && (q.size() < 16 || pop_m);
      step();
      cyc++;
      if (pop_m) void'(q.pop_front());
      if (push_m) begin q.push_back(8'(8'hC0 + sent)); sent++; end
      if (bus.o_level !== 5'(q.size())) begin
        errs++; $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", cyc, bus.o_level, q.size());
      end
    end
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    total++; if (errs != 0 || cyc >= 1000) begin bad++;
      $display("FAIL wrap_summary got errs=%0d cyc=%0d exp errs=0 cyc<1000", errs, cyc); end
  endtask

  task automatic test_err_counters();
    for (int k = 0; k < 2; k++) begin
      bus.i_parity_error = 1'b1;
      repeat (5) step();
      bus.i_parity_error = 1'b0;
      repeat (3) step();
    end
    total++; if (bus.o_par_err_cnt !== 8'd2) begin bad++; $display("FAIL par_cnt got=%0d exp=2", bus.o_par_err_cnt); end
    for (int k = 0; k < 300; k++) begin
      bus.i_stop_error = 1'b1;
      step();
      bus.i_stop_error = 1'b0;
      step();
    end
    total++; if (bus.o_stp_err_cnt !== 8'd255 || bus.o_par_err_cnt !== 8'd2) begin bad++;
      $display("FAIL stp_sat got stp=%0d par=%0d exp 255/2", bus.o_stp_err_cnt, bus.o_par_err_cnt); end
    bus.i_clr_status = 1'b1;
    step();
    bus.i_clr_status = 1'b0;
    total++; if (bus.o_stp_err_cnt !== 8'd0 || bus.o_par_err_cnt !== 8'd0 || bus.o_overrun !== 1'b0) begin bad++;
      $display("FAIL clr_status got stp=%0d par=%0d ovr=%0b exp 0/0/0", bus.o_stp_err_cnt, bus.o_par_err_cnt, bus.o_overrun); end
    bus.i_stop_error = 1'b1;
    bus.i_clr_status = 1'b1;
    step();
    bus.i_clr_status = 1'b0;
    step();
    bus.i_stop_error = 1'b0;
    total++; if (bus.o_stp_err_cnt !== 8'd1) begin bad++; $display("FAIL clr_vs_edge got=%0d exp=1", bus.o_stp_err_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'(8'h70 + i);
      step();
    end
    bus.i_wr_valid = 1'b0;
    bus.i_parity_error = 1'b1;
    step();
    bus.i_parity_error = 1'b0;
    total++; if (bus.o_level !== 5'd7 || bus.o_par_err_cnt !== 8'd1) begin bad++;
      $display("FAIL pre_reset got level=%0d par=%0d exp 7/1", bus.o_level, bus.o_par_err_cnt); end
    rst_n = 1'b0;
    step();
    total++; if (bus.o_empty !== 1'b1 || bus.o_level !== 5'd0 || bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== 8'h00) begin bad++;
      $display("FAIL mid_reset_fifo got empty=%0b level=%0d valid=%0b data=%h exp 1/0/0/00",
               bus.o_empty, bus.o_level, bus.o_rd_valid, bus.o_rd_data); end
    total++; if (bus.o_overrun !== 1'b0 || bus.o_par_err_cnt !== 8'd0 || bus.o_stp_err_cnt !== 8'd0) begin bad++;
      $display("FAIL mid_reset_status got ovr=%0b par=%0d stp=%0d exp 0/0/0", bus.o_overrun, bus.o_par_err_cnt, bus.o_stp_err_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_empty_push_ready();
    test_fill_overrun();
    test_full_push_pop();
    test_wrap_random();
    test_err_counters();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
